// File: rtl/reg_bus_arbiter_if.sv
// Register bus arbiter interface.
// Bundles the per-requester handshake (req/dir/addr/wdata in, ack/rdata out)
// together with the single-beat register bus master port. The "master" modport
// is the arbiter's view (it masters the register bus). The "slave" modport is
// the environment's view: the requesters plus the register bus target.
interface reg_bus_arbiter_if #(
    parameter int NUM_MST = 2
);
    logic [NUM_MST-1:0]   m_req;
    logic [NUM_MST-1:0]   m_dir;
    logic [8*NUM_MST-1:0] m_addr;
    logic [8*NUM_MST-1:0] m_wdata;
    logic [NUM_MST-1:0]   m_ack;
    logic [7:0]           m_rdata;
    logic                 busy;
    logic [7:0]           bus_addr;
    logic [7:0]           bus_wdata;
    logic                 bus_direction;
    logic                 bus_enable;
    logic [7:0]           bus_rdata;

    modport master (
        input  m_req, m_dir, m_addr, m_wdata, bus_rdata,
        output m_ack, m_rdata, busy, bus_addr, bus_wdata, bus_direction, bus_enable
    );

    modport slave (
        output m_req, m_dir, m_addr, m_wdata, bus_rdata,
        input  m_ack, m_rdata, busy, bus_addr, bus_wdata, bus_direction, bus_enable
    );
endinterface

// File: rtl/reg_bus_arbiter.sv
// Round-robin arbiter for an 8-bit register bus.
// One single-beat access per grant: IDLE picks a winner, ACCESS drives the
// enable strobe for one cycle, RD_WAIT waits RD_LAT cycles for read data,
// DONE pulses the winner's ack. Address/data/direction stay on the bus from
// ACCESS until the next grant; only the enable strobe drops back.
module reg_bus_arbiter #(
    parameter int NUM_MST = 2,
    parameter int RD_LAT  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    reg_bus_arbiter_if.master bus_if
);
    localparam int IDX_W = (NUM_MST > 1) ? $clog2(NUM_MST) : 1;
    localparam int CNT_W = 3;
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_MST - 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LAT - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_RD_WAIT = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    // First set request bit found searching upward from last+1 (wrapping).
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_MST-1:0] req,
                                                 input logic [IDX_W-1:0]   last);
        logic [IDX_W:0]   sum;
        logic [IDX_W-1:0] cand;
        logic [IDX_W-1:0] pick;
        logic             found;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= NUM_MST; k++) begin
            sum = {1'b0, last} + (IDX_W+1)'(k);
            if (sum >= (IDX_W+1)'(NUM_MST)) begin
                sum = sum - (IDX_W+1)'(NUM_MST);
            end else begin
                sum = sum;
            end
            cand = sum[IDX_W-1:0];
            if (req[cand] && !found) begin
                pick  = cand;
                found = 1'b1;
            end else begin
                pick  = pick;
            end
        end
        return pick;
    endfunction

    // One-hot ack vector for a requester index.
    function automatic logic [NUM_MST-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_MST-1:0] one;
        one = {{(NUM_MST-1){1'b0}}, 1'b1};
        return one << idx;
    endfunction

    state_t             state_r;
    state_t             state_nxt_s;
    logic [IDX_W-1:0]   last_r;
    logic [IDX_W-1:0]   last_nxt_s;
    logic [IDX_W-1:0]   win_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_nxt_s;
    logic [7:0]         bus_addr_r;
    logic [7:0]         addr_nxt_s;
    logic [7:0]         bus_wdata_r;
    logic [7:0]         wdata_nxt_s;
    logic               bus_dir_r;
    logic               dir_nxt_s;
    logic               bus_en_r;
    logic               en_nxt_s;
    logic [7:0]         m_rdata_r;
    logic [7:0]         rdata_nxt_s;
    logic [NUM_MST-1:0] m_ack_r;
    logic [NUM_MST-1:0] ack_nxt_s;
    logic               busy_r;
    logic               busy_nxt_s;

    assign win_s = rr_pick(bus_if.m_req, last_r);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and next-output logic; every output is registered from these.
    always_comb begin
        state_nxt_s = state_r;
        last_nxt_s  = last_r;
        cnt_nxt_s   = cnt_r;
        addr_nxt_s  = bus_addr_r;
        wdata_nxt_s = bus_wdata_r;
        dir_nxt_s   = bus_dir_r;
        rdata_nxt_s = m_rdata_r;
        case (state_r)
            ST_IDLE: begin
                if (|bus_if.m_req) begin
                    state_nxt_s = ST_ACCESS;
                    last_nxt_s  = win_s;
                    addr_nxt_s  = bus_if.m_addr[{win_s, 3'b000} +: 8];
                    wdata_nxt_s = bus_if.m_wdata[{win_s, 3'b000} +: 8];
                    dir_nxt_s   = bus_if.m_dir[win_s];
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (bus_dir_r) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RD_WAIT;
                    cnt_nxt_s   = CNT_LOAD;
                end
            end
            ST_RD_WAIT: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    state_nxt_s = ST_DONE;
                    rdata_nxt_s = bus_if.bus_rdata;
                end else begin
                    cnt_nxt_s   = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase

        en_nxt_s   = (state_nxt_s == ST_ACCESS);
        busy_nxt_s = (state_nxt_s != ST_IDLE);
        if (state_nxt_s == ST_DONE) begin
            ack_nxt_s = idx_onehot(last_nxt_s);
        end else begin
            ack_nxt_s = {NUM_MST{1'b0}};
        end
    end

    // Grant pointer, read-wait counter and registered bus/requester outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_r      <= LAST_RST;
            cnt_r       <= {CNT_W{1'b0}};
            bus_addr_r  <= 8'h00;
            bus_wdata_r <= 8'h00;
            bus_dir_r   <= 1'b0;
            bus_en_r    <= 1'b0;
            m_rdata_r   <= 8'h00;
            m_ack_r     <= {NUM_MST{1'b0}};
            busy_r      <= 1'b0;
        end else begin
            last_r      <= last_nxt_s;
            cnt_r       <= cnt_nxt_s;
            bus_addr_r  <= addr_nxt_s;
            bus_wdata_r <= wdata_nxt_s;
            bus_dir_r   <= dir_nxt_s;
            bus_en_r    <= en_nxt_s;
            m_rdata_r   <= rdata_nxt_s;
            m_ack_r     <= ack_nxt_s;
            busy_r      <= busy_nxt_s;
        end
    end

    assign bus_if.bus_addr      = bus_addr_r;
    assign bus_if.bus_wdata     = bus_wdata_r;
    assign bus_if.bus_direction = bus_dir_r;
    assign bus_if.bus_enable    = bus_en_r;
    assign bus_if.m_rdata       = m_rdata_r;
    assign bus_if.m_ack         = m_ack_r;
    assign bus_if.busy          = busy_r;
endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Bench for reg_bus_arbiter: two instances (RD_LAT=1 and RD_LAT=3) on one clock.
// Instance A is backed by a memory-style bus target; instance B's rdata is
// driven cycle by cycle from the stimulus.
module tb_reg_bus_arbiter;
    localparam int NM       = 2;
    localparam int RD_LAT_A = 1;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    reg_bus_arbiter_if #(.NUM_MST(NM)) ia ();
    reg_bus_arbiter_if #(.NUM_MST(NM)) ib ();

    reg_bus_arbiter #(.NUM_MST(NM), .RD_LAT(RD_LAT_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus_if(ia.master));
    reg_bus_arbiter #(.NUM_MST(NM), .RD_LAT(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus_if(ib.master));

    logic [7:0] tgt_mem [256];
    logic [7:0] ref_mem [256];

    assign ia.bus_rdata = tgt_mem[ia.bus_addr];

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic       mst;
        logic       dir;
        logic [7:0] addr;
        logic [7:0] wdata;
        int         exp_lat;
        logic [1:0] exp_ack;
        logic [7:0] exp_rdata;
    } vec_t;

    vec_t vt [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Bus target write happens during the enable cycle, then advance one clock.
    task automatic tick();
        if (ia.bus_enable === 1'b1 && ia.bus_direction === 1'b1) begin
            tgt_mem[ia.bus_addr] = ia.bus_wdata;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic m, input logic req, input logic dir,
                           input logic [7:0] addr, input logic [7:0] wd);
        ia.m_req[m] = req;
        ia.m_dir[m] = dir;
        ia.m_addr[{m, 3'b000} +: 8]  = addr;
        ia.m_wdata[{m, 3'b000} +: 8] = wd;
    endtask

    task automatic chk_zero(input string who, input logic [1:0] ack, input logic [7:0] rd,
                            input logic bsy, input logic [7:0] ad, input logic [7:0] wd,
                            input logic dr, input logic en);
        chk({who, " m_ack"}, ack, 0);
        chk({who, " m_rdata"}, rd, 0);
        chk({who, " busy"}, bsy, 0);
        chk({who, " bus_addr"}, ad, 0);
        chk({who, " bus_wdata"}, wd, 0);
        chk({who, " bus_direction"}, dr, 0);
        chk({who, " bus_enable"}, en, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ia.m_req = 2'b00; ib.m_req = 2'b00;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // One isolated access on instance A: latency, bus fields, ack, rdata, busy drop.
    task automatic run_vec(input vec_t v, input int id);
        int         en_cnt = 0;
        int         ack_at = -1;
        logic [1:0] ack_v  = 2'b00;
        logic [7:0] rd_v   = 8'h00;
        logic       busy_after = 1'b1;
        drive_a(v.mst, 1'b1, v.dir, v.addr, v.wdata);
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (ia.bus_enable === 1'b1) begin
                en_cnt++;
                chk($sformatf("vec%0d enable_cycle", id), c, 1);
                chk($sformatf("vec%0d bus_addr", id), ia.bus_addr, v.addr);
                chk($sformatf("vec%0d bus_direction", id), ia.bus_direction, v.dir);
                if (v.dir) chk($sformatf("vec%0d bus_wdata", id), ia.bus_wdata, v.wdata);
            end
            if (ack_at < 0 && ia.m_ack !== 2'b00) begin
                ack_at = c;
                ack_v  = ia.m_ack;
                rd_v   = ia.m_rdata;
                ia.m_req = 2'b00;
            end else if (ack_at > 0) begin
                busy_after = ia.busy;
                chk($sformatf("vec%0d ack_after", id), ia.m_ack, 0);
                break;
            end
        end
        ia.m_req = 2'b00;
        chk($sformatf("vec%0d ack_latency", id), ack_at, v.exp_lat);
        chk($sformatf("vec%0d m_ack", id), ack_v, v.exp_ack);
        if (!v.dir) chk($sformatf("vec%0d m_rdata", id), rd_v, v.exp_rdata);
        chk($sformatf("vec%0d enable_count", id), en_cnt, 1);
        chk($sformatf("vec%0d busy_after", id), busy_after, 0);
    endtask

    // Round-robin winner for two requesters: try last+1 first, otherwise last.
    function automatic logic rr2(input logic last, input logic [1:0] req);
        logic first;
        first = last + 1'b1;
        return req[first] ? first : last;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] fair_exp [4];
        int         en_c [$];
        logic [1:0] acks [$];
        int         waits;
        int         ack_at;
        int         en_cnt;
        logic [7:0] rd_v;
        logic [1:0] ack_v;

        rst_n = 1'b0;
        ia.m_req = 2'b00; ia.m_dir = 2'b00; ia.m_addr = 16'h0000; ia.m_wdata = 16'h0000;
        ib.m_req = 2'b00; ib.m_dir = 2'b00; ib.m_addr = 16'h0000; ib.m_wdata = 16'h0000;
        ib.bus_rdata = 8'h00;
        for (int a = 0; a < 256; a++) tgt_mem[a] = 8'(a) ^ 8'h5A;
        tgt_mem[8'h22] = 8'h5C;

        vt[0]  = '{1'b0, 1'b1, 8'h10, 8'hA5, 2, 2'b01, 8'h00};
        vt[1]  = '{1'b1, 1'b0, 8'h22, 8'h00, 3, 2'b10, 8'h5C};
        vt[2]  = '{1'b1, 1'b1, 8'h33, 8'h3C, 2, 2'b10, 8'h00};
        vt[3]  = '{1'b0, 1'b0, 8'h10, 8'h00, 3, 2'b01, 8'hA5};
        vt[4]  = '{1'b0, 1'b0, 8'h33, 8'h00, 3, 2'b01, 8'h3C};
        vt[5]  = '{1'b1, 1'b1, 8'hFF, 8'h00, 2, 2'b10, 8'h00};
        vt[6]  = '{1'b0, 1'b0, 8'hFF, 8'h00, 3, 2'b01, 8'h00};
        vt[7]  = '{1'b1, 1'b0, 8'h00, 8'h00, 3, 2'b10, 8'h5A};
        vt[8]  = '{1'b0, 1'b1, 8'h00, 8'hFF, 2, 2'b01, 8'h00};
        vt[9]  = '{1'b1, 1'b0, 8'h00, 8'h00, 3, 2'b10, 8'hFF};
        vt[10] = '{1'b1, 1'b0, 8'h80, 8'h00, 3, 2'b10, 8'hDA};

        // Reset state of both instances.
        tick();
        tick();
        chk_zero("reset_a", ia.m_ack, ia.m_rdata, ia.busy, ia.bus_addr, ia.bus_wdata,
                 ia.bus_direction, ia.bus_enable);
        chk_zero("reset_b", ib.m_ack, ib.m_rdata, ib.busy, ib.bus_addr, ib.bus_wdata,
                 ib.bus_direction, ib.bus_enable);
        rst_n = 1'b1;
        tick();

        // Table of isolated single accesses on instance A.
        for (int i = 0; i < 11; i++) run_vec(vt[i], i);

        // Both requesters writing continuously: grants alternate 0,1,0,1.
        fair_exp[0] = 2'b01; fair_exp[1] = 2'b10; fair_exp[2] = 2'b01; fair_exp[3] = 2'b10;
        drive_a(1'b0, 1'b1, 1'b1, 8'h41, 8'h11);
        drive_a(1'b1, 1'b1, 1'b1, 8'h42, 8'h22);
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (ia.bus_enable === 1'b1) en_c.push_back(c);
            if (ia.m_ack !== 2'b00) begin
                acks.push_back(ia.m_ack);
                if (acks.size() == 4) begin
                    ia.m_req = 2'b00;
                    break;
                end
            end
        end
        ia.m_req = 2'b00;
        chk("fair ack_count", acks.size(), 4);
        for (int k = 0; k < 4 && k < acks.size(); k++)
            chk($sformatf("fair ack%0d", k), acks[k], fair_exp[k]);
        chk("fair first_enable", (en_c.size() > 0) ? en_c[0] : -1, 1);
        for (int k = 1; k < en_c.size(); k++)
            chk($sformatf("fair enable_gap%0d", k), en_c[k] - en_c[k-1], 3);
        tick();

        // Requester 0 drops after ACCESS; requester 1 withdraws before being granted.
        drive_a(1'b0, 1'b1, 1'b1, 8'h55, 8'h66);
        tick();
        chk("drop enable", ia.bus_enable, 1);
        ia.m_req[0] = 1'b0;
        drive_a(1'b1, 1'b1, 1'b0, 8'h77, 8'h00);
        tick();
        chk("drop m_ack", ia.m_ack, 2'b01);
        ia.m_req[1] = 1'b0;
        for (int c = 3; c <= 6; c++) begin
            tick();
            chk($sformatf("drop idle_enable c%0d", c), ia.bus_enable, 0);
            chk($sformatf("drop idle_busy c%0d", c), ia.busy, 0);
            chk($sformatf("drop idle_ack c%0d", c), ia.m_ack, 0);
        end

        // RD_LAT=3 read on instance B: three wait cycles, rdata of the third.
        ib.m_req = 2'b01; ib.m_dir = 2'b00; ib.m_addr = 16'h0040;
        waits = 0; ack_at = -1; en_cnt = 0; rd_v = 8'h00; ack_v = 2'b00;
        for (int c = 1; c <= 10; c++) begin
            tick();
            ib.bus_rdata = 8'hC0 | 8'(c);
            if (ib.bus_enable === 1'b1) begin
                en_cnt++;
                chk("lat3 enable_cycle", c, 1);
            end
            if (ib.busy === 1'b1 && ib.bus_enable === 1'b0 && ib.m_ack === 2'b00) waits++;
            if (ack_at < 0 && ib.m_ack !== 2'b00) begin
                ack_at = c; ack_v = ib.m_ack; rd_v = ib.m_rdata; ib.m_req = 2'b00;
            end else if (ack_at > 0) begin
                chk("lat3 busy_after", ib.busy, 0);
                break;
            end
        end
        ib.m_req = 2'b00;
        chk("lat3 enable_count", en_cnt, 1);
        chk("lat3 wait_cycles", waits, 3);
        chk("lat3 ack_latency", ack_at, 5);
        chk("lat3 m_ack", ack_v, 2'b01);
        chk("lat3 m_rdata", rd_v, 8'hC4);
        chk("lat3 bus_addr_hold", ib.bus_addr, 8'h40);

        // Reset during RD_WAIT: outputs clear at once, no ack, pointer back to 0 first.
        ib.m_req = 2'b01; ib.m_dir = 2'b00; ib.m_addr = 16'h006E;
        tick();
        chk("mid enable", ib.bus_enable, 1);
        tick();
        chk("mid busy_before", ib.busy, 1);
        chk("mid addr_before", ib.bus_addr, 8'h6E);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("mid_reset_b", ib.m_ack, ib.m_rdata, ib.busy, ib.bus_addr, ib.bus_wdata,
                 ib.bus_direction, ib.bus_enable);
        ib.m_req = 2'b00;
        tick();
        chk("mid ack_in_reset1", ib.m_ack, 0);
        tick();
        chk("mid ack_in_reset2", ib.m_ack, 0);
        rst_n = 1'b1;
        ib.m_req = 2'b11; ib.m_dir = 2'b11; ib.m_addr = 16'h0201; ib.m_wdata = 16'hBBAA;
        ack_at = -1; ack_v = 2'b00;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (ib.bus_enable === 1'b1 && c == 1) chk("post_reset first_addr", ib.bus_addr, 8'h01);
            if (ib.m_ack !== 2'b00) begin
                ack_at = c; ack_v = ib.m_ack; ib.m_req = 2'b00;
                break;
            end
        end
        ib.m_req = 2'b00;
        chk("post_reset ack_latency", ack_at, 2);
        chk("post_reset first_grant", ack_v, 2'b01);

        // Randomized traffic on instance A against a transaction-level model.
        do_reset();
        for (int a = 0; a < 256; a++) begin
            tgt_mem[a] = 8'(a) ^ 8'h5A;
            ref_mem[a] = 8'(a) ^ 8'h5A;
        end
        begin
            int         grant_c = -100;
            int         exp_ack_c = -100;
            logic       ref_last = 1'b1;
            logic       g_idx = 1'b0;
            logic       g_dir = 1'b0;
            logic [7:0] g_addr = 8'h00;
            logic [7:0] g_wd = 8'h00;
            logic [1:0] pend = 2'b00;
            logic [1:0] req_now;
            logic [1:0] oh;
            logic       mi;
            for (int n = 1; n <= 3000; n++) begin
                req_now = ia.m_req;
                tick();
                if (n >= exp_ack_c + 2 && req_now != 2'b00) begin
                    g_idx     = rr2(ref_last, req_now);
                    ref_last  = g_idx;
                    g_dir     = ia.m_dir[g_idx];
                    g_addr    = ia.m_addr[{g_idx, 3'b000} +: 8];
                    g_wd      = ia.m_wdata[{g_idx, 3'b000} +: 8];
                    grant_c   = n;
                    exp_ack_c = g_dir ? n + 1 : n + 1 + RD_LAT_A;
                end
                oh = g_idx ? 2'b10 : 2'b01;
                chk($sformatf("rnd enable n%0d", n), ia.bus_enable, (n == grant_c) ? 1 : 0);
                chk($sformatf("rnd busy n%0d", n), ia.busy,
                    (n >= grant_c && n <= exp_ack_c) ? 1 : 0);
                chk($sformatf("rnd m_ack n%0d", n), ia.m_ack, (n == exp_ack_c) ? oh : 2'b00);
                if (n == grant_c) begin
                    chk($sformatf("rnd bus_addr n%0d", n), ia.bus_addr, g_addr);
                    chk($sformatf("rnd bus_dir n%0d", n), ia.bus_direction, g_dir);
                    if (g_dir) chk($sformatf("rnd bus_wdata n%0d", n), ia.bus_wdata, g_wd);
                end
                if (n == exp_ack_c) begin
                    if (g_dir) ref_mem[g_addr] = g_wd;
                    else chk($sformatf("rnd m_rdata n%0d", n), ia.m_rdata, ref_mem[g_addr]);
                end
                for (int i = 0; i < NM; i++) begin
                    mi = i[0];
                    if (pend[mi] && n == exp_ack_c && g_idx == mi) begin
                        pend[mi] = 1'b0;
                        ia.m_req[mi] = 1'b0;
                    end else if (!pend[mi] && $urandom_range(0, 3) == 0) begin
                        pend[mi] = 1'b1;
                        drive_a(mi, 1'b1, 1'($urandom_range(0, 1)),
                                8'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
                    end
                end
            end
        end
        ia.m_req = 2'b00;
        for (int c = 0; c < 8; c++) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/reg_bus_arbiter.md
Name: reg_bus_arbiter

Overview:
Arbitrates the 8-bit register bus (wdata/addr/direction/enable out, rdata in) between NUM_MST independent requesters, such as the RAL driver and a background scrubber or auto-mirror engine. It grants round-robin, runs exactly one single-beat bus access per grant, and returns write completion or read data to the winning requester. It sits between the requesters and the bus master port, one instance per register bus.

Parameters:
NUM_MST, 2, number of requesters (2..8)
RD_LAT, 1, clock cycles from the enable cycle to the cycle in which bus rdata is valid (1..4)

Ports:
clk  input  1  bus clock; all logic on posedge
rst_n  input  1  asynchronous active-low reset
m_req  input  NUM_MST  per-requester access request, level
m_dir  input  NUM_MST  per-requester direction; 1 = write, 0 = read
m_addr  input  8*NUM_MST  per-requester address, packed; requester i at [8i+7:8i]
m_wdata  input  8*NUM_MST  per-requester write data, packed as m_addr
m_ack  output  NUM_MST  one-cycle completion pulse to the granted requester
m_rdata  output  8  read data; valid only in the m_ack cycle of a read
busy  output  1  high whenever the FSM is not in IDLE
bus_addr  output  8  register bus address
bus_wdata  output  8  register bus write data
bus_direction  output  1  register bus direction; 1 = write
bus_enable  output  1  register bus access strobe
bus_rdata  input  8  register bus read data

Behaviour:
- Reset (async assert, sync release): FSM=IDLE; m_ack=0, m_rdata=0, busy=0, bus_addr=0, bus_wdata=0, bus_direction=0, bus_enable=0; last-grant pointer = NUM_MST-1, so requester 0 has first priority.
- All outputs are registered.
- FSM states: IDLE, ACCESS, RD_WAIT, DONE.
- IDLE:
  - If any m_req bit is set, pick the winner g: search starts at (last+1) mod NUM_MST and takes the first set bit.
  - Latch m_dir[g], m_addr[g] and m_wdata[g] onto the bus_* registers, set last=g, go to ACCESS.
  - If no request, stay in IDLE.
- ACCESS: exactly one cycle with bus_enable=1.
  - Write: go to DONE.
  - Read: go to RD_WAIT and load counter = RD_LAT-1.
- RD_WAIT: bus_enable=0.
  - Counter decrements each cycle.
  - When counter==0, capture bus_rdata into m_rdata and go to DONE.
  - Total read wait is RD_LAT cycles.
- DONE: m_ack[g]=1 for exactly this cycle; next state IDLE.
  - For a write, m_rdata keeps its previous value and is not meaningful.
- Bus hold: bus_addr, bus_wdata and bus_direction stay stable from ACCESS through DONE. They keep their last value in IDLE until the next grant. Only bus_enable returns to 0.
- Latency from req sampled in IDLE to m_ack:
  - write: 2 cycles (ACCESS, DONE);
  - read: 2+RD_LAT cycles.
  - Minimum spacing between bus_enable pulses: write 3 cycles, read 3+RD_LAT cycles.
- Requester rules:
  - Hold req, dir, addr and wdata stable until m_ack; drop req the cycle after m_ack unless another access is wanted.
  - req is sampled only in IDLE.
  - A req withdrawn before grant is simply not served.
  - A req dropped after grant does not abort the access; the access completes and m_ack still pulses.
- A requester holding req continuously is served again only after every other active requester has had one grant (fairness). With a single active requester, back-to-back grants are allowed.
- m_ack is one-hot or zero, and is never asserted outside DONE.
- Reset mid-transaction: all outputs clear immediately; the in-flight access is lost with no m_ack; the pointer returns to its reset value.

Test Plan:
- Reset, then m_req=01 write, addr=0x10, wdata=0xA5 -> cycle+1: bus_enable=1, direction=1, addr=0x10, wdata=0xA5; cycle+2: m_ack=01; busy low at cycle+3.
- RD_LAT=1, m_req=10 read, addr=0x22; bus model returns 0x5C the cycle after enable -> m_ack=10 at cycle+3 with m_rdata=0x5C.
- m_req=11 held continuously, both doing writes -> grant order 0,1,0,1; bus_enable pulses exactly 3 cycles apart; m_ack alternates 01,10.
- RD_LAT=3 read -> exactly 3 RD_WAIT cycles; bus_enable high for exactly 1 cycle; m_ack at cycle+5 carries the rdata present in the 3rd wait cycle.
- Requester 0 drops req the cycle after ACCESS -> access completes, m_ack[0] pulses; next IDLE sees no req and stays idle.
- rst_n asserted during RD_WAIT -> all outputs 0 the same cycle, no m_ack; after release, m_req=11 grants requester 0 first.
